// File: rtl/pattern_det_pkg.sv
// Shared defaults and next-state helper for the serial pattern detector.
//   DEF_PATTERN_LEN / DEF_PATTERN : default pattern (MSB received first)
//   next_state()                  : KMP automaton step, evaluated at elaboration
package pattern_det_pkg;

  localparam int unsigned MAX_LEN         = 16;
  localparam int unsigned DEF_PATTERN_LEN = 5;
  localparam logic [DEF_PATTERN_LEN-1:0] DEF_PATTERN = 5'b10110;

  // Returns the matched-prefix length after accepting bit b in state 'state'.
  // A full match folds back to the longest proper border of the pattern.
  function automatic int unsigned next_state(input int unsigned     state,
                                             input logic            b,
                                             input logic [MAX_LEN-1:0] pat,
                                             input int unsigned     len);
    int unsigned fail [MAX_LEN+1];
    int unsigned k;
    int unsigned s;
    int unsigned res;
    logic        done;

    // fail[i] = longest proper border of the i-bit pattern prefix
    for (int unsigned i = 0; i <= MAX_LEN; i++) fail[5'(i)] = 0;
    k = 0;
    for (int unsigned i = 1; i < MAX_LEN; i++) begin
      if (i < len) begin
        for (int unsigned j = 0; j < MAX_LEN; j++) begin
          if (k > 0 && pat[4'(len-1-i)] != pat[4'(len-1-k)]) k = fail[5'(k)];
        end
        if (pat[4'(len-1-i)] == pat[4'(len-1-k)]) k = k + 1;
        fail[5'(i+1)] = k;
      end
    end

    s    = (state >= len) ? 0 : state;
    res  = 0;
    done = 1'b0;
    for (int unsigned j = 0; j <= MAX_LEN; j++) begin
      if (!done) begin
        if (b == pat[4'(len-1-s)]) begin
          res  = (s + 1 == len) ? fail[5'(len)] : s + 1;
          done = 1'b1;
        end else if (s == 0) begin
          res  = 0;
          done = 1'b1;
        end else begin
          s = fail[5'(s)];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pattern_det_nxt.sv
// Combinational next-state and final-bit match logic for pattern_det.
//   state_i      : current matched-prefix length
//   d_i          : incoming data bit
//   next_state_o : state after accepting d_i
//   match_o      : d_i completes the full pattern from state_i
module pattern_det_nxt
  import pattern_det_pkg::*;
#(
  parameter int unsigned PATTERN_LEN = DEF_PATTERN_LEN,
  parameter logic [PATTERN_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int unsigned STATE_W = $clog2(PATTERN_LEN)
) (
  input  logic [STATE_W-1:0] state_i,
  input  logic               d_i,
  output logic [STATE_W-1:0] next_state_o,
  output logic               match_o
);

  localparam int unsigned NUM_ST = 2 ** STATE_W;
  localparam logic [MAX_LEN-1:0] PAT_EXT = MAX_LEN'(PATTERN);

  logic [STATE_W-1:0] tbl0 [NUM_ST];
  logic [STATE_W-1:0] tbl1 [NUM_ST];

  // Transition tables as constants; unreachable encodings fall back to 0
  for (genvar s = 0; s < NUM_ST; s++) begin : g_tbl
    localparam int unsigned N0 = (s < PATTERN_LEN) ?
                                 next_state(s, 1'b0, PAT_EXT, PATTERN_LEN) : 0;
    localparam int unsigned N1 = (s < PATTERN_LEN) ?
                                 next_state(s, 1'b1, PAT_EXT, PATTERN_LEN) : 0;
    assign tbl0[s] = STATE_W'(N0);
    assign tbl1[s] = STATE_W'(N1);
  end

  assign next_state_o = d_i ? tbl1[state_i] : tbl0[state_i];
  assign match_o      = (state_i == STATE_W'(PATTERN_LEN - 1)) && (d_i == PATTERN[0]);

endmodule

// File: rtl/pattern_det.sv
// Serial bit-pattern detector (Mealy, overlapping matches counted).
//   clk, rst         : clock and synchronous active-high reset
//   d_in, valid_in   : serial data bit and its qualifier
//   pattern_detected : high in the cycle the accepted d_in completes the pattern
module pattern_det
  import pattern_det_pkg::*;
#(
  parameter int unsigned PATTERN_LEN = DEF_PATTERN_LEN,
  parameter logic [PATTERN_LEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  input  logic valid_in,
  output logic pattern_detected
);

  localparam int unsigned STATE_W = $clog2(PATTERN_LEN);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [STATE_W-1:0] nxt_state;
  logic               match;

  pattern_det_nxt #(
    .PATTERN_LEN(PATTERN_LEN),
    .PATTERN    (PATTERN),
    .STATE_W    (STATE_W)
  ) u_nxt (
    .state_i     (state_q),
    .d_i         (d_in),
    .next_state_o(nxt_state),
    .match_o     (match)
  );

  // Idle cycles hold state so d_in is never looked at
  always_comb begin
    state_d = state_q;
    if (valid_in) state_d = nxt_state;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  // Zero-latency flag, forced low during reset and idle cycles
  assign pattern_detected = !rst && valid_in && match;

endmodule

// File: tb/tb_pattern_det.sv
// Directed bench for pattern_det with default pattern 10110.
module tb_pattern_det;

  logic clk = 1'b0;
  logic rst;
  logic d_in;
  logic valid_in;
  logic pattern_detected;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned edges = 0;
  logic        prev_flag = 1'b0;

  logic [4:0]  win;
  int unsigned acc_cnt;
  int unsigned ref_edges;
  logic        ref_prev;
  logic        exp_bit;
  logic        rb;

  pattern_det dut (
    .clk             (clk),
    .rst             (rst),
    .d_in            (d_in),
    .valid_in        (valid_in),
    .pattern_detected(pattern_detected)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic obs, input logic exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check the Mealy flag before the edge, track rising edges
  task automatic send(input logic d, input logic v, input logic exp, input string tag);
    @(negedge clk);
    d_in = d;
    valid_in = v;
    #1;
    chk(pattern_detected, exp, tag);
    if (pattern_detected && !prev_flag) edges++;
    prev_flag = pattern_detected;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid_in = 1'b0;
    d_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    prev_flag = 1'b0;
    edges = 0;
  endtask

  initial begin
    rst = 1'b1;
    d_in = 1'b0;
    valid_in = 1'b0;

    // Reset state
    @(negedge clk);
    valid_in = 1'b1;
    #1;
    chk(pattern_detected, 1'b0, "rst_flag");
    @(negedge clk);
    total++;
    assert (dut.state_q === 3'd0) else begin
      bad++;
      $error("FAIL rst_state observed=%0d expected=0", dut.state_q);
    end
    rst = 1'b0;
    valid_in = 1'b0;

    // Single pattern
    send(1'b1, 1'b1, 1'b0, "t1_b1");
    send(1'b0, 1'b1, 1'b0, "t1_b2");
    send(1'b1, 1'b1, 1'b0, "t1_b3");
    send(1'b1, 1'b1, 1'b0, "t1_b4");
    send(1'b0, 1'b1, 1'b1, "t1_b5");

    // Overlapping occurrences
    do_reset();
    send(1'b1, 1'b1, 1'b0, "t2_b1");
    send(1'b0, 1'b1, 1'b0, "t2_b2");
    send(1'b1, 1'b1, 1'b0, "t2_b3");
    send(1'b1, 1'b1, 1'b0, "t2_b4");
    send(1'b0, 1'b1, 1'b1, "t2_b5");
    send(1'b1, 1'b1, 1'b0, "t2_b6");
    send(1'b1, 1'b1, 1'b0, "t2_b7");
    send(1'b0, 1'b1, 1'b1, "t2_b8");
    total++;
    assert (edges == 2) else begin
      bad++;
      $error("FAIL t2_edges observed=%0d expected=2", edges);
    end

    // Valid gaps with junk data
    do_reset();
    send(1'b1, 1'b1, 1'b0, "t3_b1");
    send(1'b0, 1'b1, 1'b0, "t3_b2");
    send(1'b1, 1'b1, 1'b0, "t3_b3");
    send(1'b1, 1'b0, 1'b0, "t3_g1");
    send(1'b1, 1'b0, 1'b0, "t3_g2");
    send(1'b0, 1'b0, 1'b0, "t3_g3");
    send(1'b1, 1'b1, 1'b0, "t3_b4");
    send(1'b0, 1'b1, 1'b1, "t3_b5");
    total++;
    assert (edges == 1) else begin
      bad++;
      $error("FAIL t3_edges observed=%0d expected=1", edges);
    end

    // Reset mid-sequence, with the completing bit present during reset
    do_reset();
    send(1'b1, 1'b1, 1'b0, "t4_b1");
    send(1'b0, 1'b1, 1'b0, "t4_b2");
    send(1'b1, 1'b1, 1'b0, "t4_b3");
    send(1'b1, 1'b1, 1'b0, "t4_b4");
    @(negedge clk);
    rst = 1'b1;
    d_in = 1'b0;
    valid_in = 1'b1;
    #1;
    chk(pattern_detected, 1'b0, "t4_flag_in_rst");
    @(negedge clk);
    rst = 1'b0;
    total++;
    assert (dut.state_q === 3'd0) else begin
      bad++;
      $error("FAIL t4_state observed=%0d expected=0", dut.state_q);
    end
    send(1'b0, 1'b1, 1'b0, "t4_b5");

    // Non-matching runs
    do_reset();
    for (int i = 0; i < 8; i++) send(1'b1, 1'b1, 1'b0, $sformatf("t5_one%0d", i));
    for (int i = 0; i < 8; i++) send(1'b0, 1'b1, 1'b0, $sformatf("t5_zero%0d", i));
    total++;
    assert (edges == 0) else begin
      bad++;
      $error("FAIL t5_edges observed=%0d expected=0", edges);
    end

    // Random stream against a sliding-window reference
    do_reset();
    rb = 1'(($urandom(361786)) & 1);
    win = 5'd0;
    acc_cnt = 0;
    ref_edges = 0;
    ref_prev = 1'b0;
    for (int i = 0; i < 540; i++) begin
      rb = 1'($urandom() & 1);
      win = {win[3:0], rb};
      acc_cnt++;
      exp_bit = (acc_cnt >= 5) && (win == 5'b10110);
      if (exp_bit && !ref_prev) ref_edges++;
      ref_prev = exp_bit;
      send(rb, 1'b1, exp_bit, $sformatf("rnd_b%0d", i));
    end
    total++;
    assert (edges == ref_edges) else begin
      bad++;
      $error("FAIL rnd_edges observed=%0d expected=%0d", edges, ref_edges);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
